// File: rtl/slice_scheduler.sv
// slice_scheduler: times revolutions from hall pulses, splits each into NUM_SLICES slices and scans SCAN_RATE rows per slice.
// Optional SLICE_OFFSET_EN adds slice_offset_in, a rotational offset sampled at each slice start.
module slice_scheduler #(
  parameter int SCAN_RATE  = 32,
  parameter int NUM_SLICES = 128,
  parameter int PERIOD_W   = 32,
  parameter int MIN_PERIOD = 1024
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          hall_in,
  input  logic                          col_ready_in,
`ifdef SLICE_OFFSET_EN
  input  logic [$clog2(NUM_SLICES)-1:0] slice_offset_in,
`endif
  output logic                          col_valid_out,
  output logic [$clog2(SCAN_RATE)-1:0]  column_index1_out,
  output logic [$clog2(SCAN_RATE):0]    column_index2_out,
  output logic [$clog2(NUM_SLICES)-1:0] slice_out,
  output logic                          slice_done_out,
  output logic                          locked_out,
  output logic                          overrun_out,
  output logic [PERIOD_W-1:0]           period_out
);
  localparam int RW = $clog2(SCAN_RATE);
  localparam int SW = $clog2(NUM_SLICES);
  typedef enum logic [1:0] {IDLE, WAIT_SLICE, SCAN} state_t;
  state_t r_state, w_state_nxt;
  logic [PERIOD_W-1:0] r_rev_cnt, r_period, r_timer, w_rev_inc, w_len_raw, w_len;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [SW-1:0] r_slice;
  logic r_seen, r_locked, r_done, r_overrun;
  logic w_accept, w_unlock, w_hall_start, w_term, w_tick, w_start, w_fire, w_last, w_done_nxt, w_ovr_nxt;
  assign w_rev_inc = &r_rev_cnt ? r_rev_cnt : r_rev_cnt + 1'b1;
  assign w_accept = hall_in && (w_rev_inc >= PERIOD_W'(MIN_PERIOD) || (r_state == IDLE && !r_seen));
  // Unlock is judged on the next counter value so locked_out drops as rev_cnt reaches 2*period.
  assign w_unlock = r_locked && !w_accept && (({1'b0, w_rev_inc} >= {r_period, 1'b0}) || &w_rev_inc);
  assign w_hall_start = w_accept && r_seen;
  assign w_len_raw = r_period >> SW;
  assign w_len = (w_len_raw == '0) ? PERIOD_W'(1) : w_len_raw;
  assign w_term = r_timer >= w_len - 1'b1;
  assign w_tick = r_locked && w_term && !(&r_slice);
  assign w_start = w_hall_start || (w_tick && !w_unlock);
  assign w_fire = (r_state == SCAN) && col_ready_in;
  assign w_last = w_fire && (&r_row);
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt = r_row;
    w_done_nxt = 1'b0;
    w_ovr_nxt = r_overrun;
    if (w_unlock) begin
      w_state_nxt = IDLE;
      w_row_nxt = '0;
    end else if (w_start) begin
      // A final pair accepted on the boundary completes its slice rather than overrunning it.
      w_state_nxt = SCAN;
      w_row_nxt = '0;
      w_done_nxt = w_last;
      w_ovr_nxt = r_overrun || (r_state == SCAN && !w_last);
    end else if (w_last) begin
      w_state_nxt = WAIT_SLICE;
      w_done_nxt = 1'b1;
    end else if (w_fire) begin
      w_row_nxt = r_row + 1'b1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rev_cnt <= '0;
      r_period <= '0;
      r_seen <= 1'b0;
      r_locked <= 1'b0;
      r_timer <= '0;
      r_slice <= '0;
      r_row <= '0;
      r_done <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_rev_cnt <= w_accept ? '0 : w_rev_inc;
      if (w_accept) r_period <= w_rev_inc;
      r_seen <= !w_unlock && (r_seen || w_accept);
      r_locked <= !w_unlock && (r_locked || w_hall_start);
      r_timer <= (w_hall_start || w_unlock || !r_locked || w_term) ? '0 : r_timer + 1'b1;
      r_slice <= (w_hall_start || w_unlock) ? '0 : w_tick ? r_slice + 1'b1 : r_slice;
      r_row <= w_row_nxt;
      r_done <= w_done_nxt;
      r_overrun <= w_ovr_nxt;
    end
  end
`ifdef SLICE_OFFSET_EN
  logic [SW-1:0] r_slice_out;
  always_ff @(posedge clk_in) begin
    if (!rst_in || w_unlock) r_slice_out <= '0;
    else if (w_start) r_slice_out <= (w_hall_start ? '0 : r_slice + 1'b1) + slice_offset_in;
  end
  assign slice_out = r_slice_out;
`else
  assign slice_out = r_slice;
`endif
  assign col_valid_out = r_state == SCAN;
  assign column_index1_out = col_valid_out ? r_row : '0;
  assign column_index2_out = col_valid_out ? {1'b1, r_row} : '0;
  assign slice_done_out = r_done;
  assign locked_out = r_locked;
  assign overrun_out = r_overrun;
  assign period_out = r_period;
endmodule

// File: doc/slice_scheduler.md
Name: slice_scheduler

Overview:
- Sequences the per-slice column generator for the rotating POV panel.
- Measures revolution period from the hall-sensor pulse and divides each revolution into NUM_SLICES equal angular slices.
- For each slice, walks scan rows 0..SCAN_RATE-1 and presents column_index1/column_index2 pairs to the generator. Each pair is handed to the HUB75 shifter via a valid/ready handshake.

Parameters:
- SCAN_RATE, 32, scan rows per slice; power of two.
- NUM_SLICES, 128, slices per revolution; power of two.
- PERIOD_W, 32, width of revolution-period counter.
- MIN_PERIOD, 1024, accepted hall pulses closer than this (cycles) are ignored (debounce).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- hall_in  input  1  one-cycle pulse per revolution, already synchronised
- col_ready_in  input  1  downstream shifter accepts current column pair
- col_valid_out  output  1  column pair valid
- column_index1_out  output  $clog2(SCAN_RATE)  scan row (upper half column)
- column_index2_out  output  $clog2(SCAN_RATE)+1  scan row + SCAN_RATE (lower half column)
- slice_out  output  $clog2(NUM_SLICES)  current angular slice
- slice_done_out  output  1  one-cycle pulse after last row of a slice accepted
- locked_out  output  1  period measurement valid
- overrun_out  output  1  sticky: slice boundary arrived mid-scan
- period_out  output  PERIOD_W  last accepted revolution period, cycles

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous, active-low on rst_in.
- Reset values: all outputs 0, state IDLE, rev_cnt 0, period 0.
- Revolution counter:
  - rev_cnt increments every cycle, saturating at all-ones.
  - A hall pulse is accepted iff rev_cnt+1 >= MIN_PERIOD, or the block is in IDLE with no prior pulse.
  - On an accepted pulse: period_out <= rev_cnt+1, rev_cnt <= 0. Rejected pulses have no effect.
- Lock:
  - locked_out rises on the second accepted pulse after reset or unlock.
  - It falls when rev_cnt reaches 2*period_out or saturates. Unlock forces IDLE, drops col_valid_out and sets slice_out=0.
- Slice timing:
  - slice_len = period_out >> log2(NUM_SLICES), forced to 1 if 0.
  - The slice timer counts 0..slice_len-1. At terminal count, slice_tick fires and slice_out increments.
  - slice_out saturates at NUM_SLICES-1; no further ticks until the next hall pulse.
  - An accepted hall pulse while locked: slice_out <= 0, timer <= 0, and a slice start is generated.
  - Hall and tick in the same cycle: hall wins; exactly one slice start, for slice 0.
  - The pulse that asserts lock also generates a slice-0 start.
- FSM states: IDLE, WAIT_SLICE, SCAN.
  - IDLE -> WAIT_SLICE when locked_out rises (same cycle as the slice-0 start, which is taken immediately → SCAN).
  - WAIT_SLICE -> SCAN on slice start; row <= 0.
  - SCAN: col_valid_out=1, column_index1_out=row, column_index2_out=row+SCAN_RATE.
    - On valid&&ready: row increments. If row==SCAN_RATE-1, slice_done_out pulses next cycle and the FSM goes to WAIT_SLICE (col_valid_out=0).
    - Outputs hold stable while valid&&!ready.
  - Slice start while in SCAN (overrun): overrun_out <= 1 (sticky until reset), row <= 0, stay in SCAN for the new slice, no slice_done_out for the aborted slice.
  - Any state -> IDLE on unlock.
- Latency: slice start event in cycle N → col_valid_out=1 with row 0 in cycle N+1.
- Reset mid-scan: next cycle all outputs at reset values; no partial slice_done_out.

Optional Feature:
- Macro: SLICE_OFFSET_EN.
- Defined:
  - Adds input slice_offset_in, width $clog2(NUM_SLICES).
  - slice_out = (internal slice + slice_offset_in) mod NUM_SLICES, registered, same cycle alignment as internal slice.
  - Offset is sampled only at slice start, so changes never alter slice_out mid-scan.
- Undefined: no port; slice_out equals the internal slice.

Test Plan:
- Bench override SCAN_RATE=4, NUM_SLICES=8, MIN_PERIOD=16 for all scenarios.
- Hall pulses 800 cycles apart, ready=1 → locked_out=1 on 2nd pulse, period_out=800, slice_out 0..7 advancing every 100 cycles, 4 valid pairs per slice (idx1 0..3, idx2 4..7), slice_done_out 8 times per revolution.
- Ready held low 3 cycles on row 2 → indices hold 2/6 with valid high; row 3 follows; exactly 4 acceptances.
- Ready=0 for a whole slice (100 cycles) → overrun_out=1 at the next slice boundary; row restarts at 0 for slice+1; no slice_done_out for the aborted slice.
- Glitch pulse 10 cycles after an accepted pulse → ignored; period_out unchanged, slice_out unaffected.
- Hall stops after lock (period 800) → locked_out falls at rev_cnt=1600, col_valid_out=0, state IDLE. Two pulses 800 apart re-lock.
- rst_in=0 for one cycle mid-SCAN → all outputs 0 the following cycle; relock requires two pulses.
- With SLICE_OFFSET_EN, slice_offset_in=6 → slice_out sequence 6,7,0,1,…,5 per revolution.
